// File: rtl/mac_multiplex_pkg.sv
// Shared types and constant tables for the mac_multiplex job sequencer.
// The lookup tables turn a precision mode into the MAC configuration words.
package mac_multiplex_pkg;

  typedef enum logic [1:0] {
    FULL    = 2'd0,
    HALF    = 2'd1,
    QUARTER = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int SC_WIDTH = 7;

  // Indexed by mode; slot 3 is never addressed after sanitising but is
  // filled with the FULL encoding so the table covers every index value.
  localparam logic [1:0] AW_LUT [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
  localparam logic [SC_WIDTH-1:0] SC_LUT [4] = '{7'b0101000, 7'b0100110,
                                                  7'b0000101, 7'b0101000};

  // The reserved mode code runs as a full-width job.
  function automatic mode_t mode_sanitize(input logic [1:0] raw);
    case (raw)
      2'd1:    return HALF;
      2'd2:    return QUARTER;
      default: return FULL;
    endcase
  endfunction

endpackage

// File: rtl/mac_multiplex.sv
// Behavioural multi-precision MAC: one 8x8 lane, two 4x4 lanes or four 2x2
// lanes (signed weights, unsigned activations), with a product register
// followed by a lane-wise accumulator. accu_rst clears both stages.
module mac_multiplex #(
  parameter int W_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int PLUS_WIDTH = 4,
  parameter int CONFIG_AW_WIDTH = 2,
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + 4 * PLUS_WIDTH,
  localparam int SC_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W_WIDTH-1:0]         w,
  input  logic [A_WIDTH-1:0]         a,
  input  logic                       accu_rst,
  input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
  input  logic [SC_WIDTH-1:0]        config_sc,
  output logic [Z_WIDTH-1:0]         z
);

  localparam int ZH = Z_WIDTH / 2;
  localparam int ZQ = Z_WIDTH / 4;
  localparam int WH = W_WIDTH / 2;
  localparam int WQ = W_WIDTH / 4;
  localparam int AH = A_WIDTH / 2;
  localparam int AQ = A_WIDTH / 4;

  logic [Z_WIDTH-1:0] prod_full;
  logic [Z_WIDTH-1:0] prod_half;
  logic [Z_WIDTH-1:0] prod_quarter;
  logic [Z_WIDTH-1:0] sum_full;
  logic [Z_WIDTH-1:0] sum_half;
  logic [Z_WIDTH-1:0] sum_quarter;
  logic [Z_WIDTH-1:0] mult_d;
  logic [Z_WIDTH-1:0] acc_d;
  logic [Z_WIDTH-1:0] mult;
  logic [Z_WIDTH-1:0] acc;

  // The lane split is fully described by config_aw in this model.
  logic unused_sc;
  assign unused_sc = ^config_sc;

  // Per-lane products and lane-wise sums; carries never cross lane borders.
  always_comb begin
    prod_full    = Z_WIDTH'($signed(w)) * Z_WIDTH'($signed({1'b0, a}));
    prod_half    = '0;
    prod_quarter = '0;
    sum_full     = acc + mult;
    sum_half     = '0;
    sum_quarter  = '0;
    for (int i = 0; i < 2; i++) begin
      prod_half[i*ZH +: ZH] = ZH'($signed(w[i*WH +: WH])) *
                              ZH'($signed({1'b0, a[i*AH +: AH]}));
      sum_half[i*ZH +: ZH]  = acc[i*ZH +: ZH] + mult[i*ZH +: ZH];
    end
    for (int i = 0; i < 4; i++) begin
      prod_quarter[i*ZQ +: ZQ] = ZQ'($signed(w[i*WQ +: WQ])) *
                                 ZQ'($signed({1'b0, a[i*AQ +: AQ]}));
      sum_quarter[i*ZQ +: ZQ]  = acc[i*ZQ +: ZQ] + mult[i*ZQ +: ZQ];
    end
    case (config_aw)
      2'b01: begin
        mult_d = prod_half;
        acc_d  = sum_half;
      end
      2'b11: begin
        mult_d = prod_quarter;
        acc_d  = sum_quarter;
      end
      default: begin
        mult_d = prod_full;
        acc_d  = sum_full;
      end
    endcase
  end

  // Two-stage pipeline: register the product, then fold it into the sum.
  always_ff @(posedge clk) begin
    if (rst || accu_rst) begin
      mult <= '0;
      acc  <= '0;
    end else begin
      mult <= mult_d;
      acc  <= acc_d;
    end
  end

  assign z = acc;

endmodule

// File: rtl/mac_multiplex_ctrl.sv
// Job sequencer for mac_multiplex: clears the accumulator, streams cfg_len
// operand beats, waits out the two-stage MAC pipeline and holds the result
// until the consumer takes it.
module mac_multiplex_ctrl
  import mac_multiplex_pkg::*;
#(
  parameter int W_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int PLUS_WIDTH = 4,
  parameter int CONFIG_AW_WIDTH = 2,
  parameter int LEN_WIDTH = 16,
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + 4 * PLUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 cfg_mode,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_WIDTH-1:0]         in_w,
  input  logic [A_WIDTH-1:0]         in_a,
  output logic [W_WIDTH-1:0]         mac_w,
  output logic [A_WIDTH-1:0]         mac_a,
  output logic                       mac_accu_rst,
  output logic [CONFIG_AW_WIDTH-1:0] mac_config_aw,
  output logic [SC_WIDTH-1:0]        mac_config_sc,
  input  logic [Z_WIDTH-1:0]         mac_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [Z_WIDTH-1:0]         res_z,
  output logic [1:0]                 res_mode
);

  if (CONFIG_AW_WIDTH != 2) begin : g_cfg_check
    $error("mac_multiplex_ctrl: CONFIG_AW_WIDTH must be 2");
  end

  state_t                     state;
  state_t                     state_next;
  mode_t                      mode_q;
  mode_t                      mode_in;
  logic [LEN_WIDTH-1:0]       cnt;
  logic [CONFIG_AW_WIDTH-1:0] aw_q;
  logic [SC_WIDTH-1:0]        sc_q;
  logic                       accu_rst_q;
  logic                       drain_second;
  logic                       fire;

  assign mode_in = mode_sanitize(cfg_mode);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the Moore/handshake outputs of each state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    fire       = 1'b0;
    mac_w      = '0;
    mac_a      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = (cnt != '0) ? RUN : DRAIN;
      end
      RUN: begin
        in_ready = 1'b1;
        fire     = in_valid;
        if (in_valid) begin
          mac_w = in_w;
          mac_a = in_a;
        end
        if (cnt == '0 || (in_valid && cnt == LEN_WIDTH'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_second) begin
          state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job context, beat counter, drain phase and the captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= FULL;
      cnt          <= '0;
      aw_q         <= AW_LUT[FULL];
      sc_q         <= SC_LUT[FULL];
      accu_rst_q   <= 1'b0;
      drain_second <= 1'b0;
      res_z        <= '0;
      res_mode     <= 2'd0;
    end else begin
      accu_rst_q   <= (state_next == CLEAR);
      drain_second <= (state == DRAIN) && !drain_second;
      if (state == IDLE && start) begin
        mode_q <= mode_in;
        cnt    <= cfg_len;
        aw_q   <= AW_LUT[mode_in];
        sc_q   <= SC_LUT[mode_in];
      end else if (fire && cnt != '0) begin
        cnt <= cnt - LEN_WIDTH'(1);
      end
      if (state == DRAIN && drain_second) begin
        res_z    <= mac_z;
        res_mode <= mode_q;
      end
    end
  end

  assign mac_accu_rst  = accu_rst_q;
  assign mac_config_aw = aw_q;
  assign mac_config_sc = sc_q;

endmodule

// File: tb/tb_mac_multiplex_ctrl.sv
// Bench for mac_multiplex_ctrl driving a mac_multiplex instance.
// Expected results are queued when a job is launched and popped on DONE.
module tb_mac_multiplex_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_w;
  logic [7:0]  in_a;
  logic [7:0]  mac_w;
  logic [7:0]  mac_a;
  logic        mac_accu_rst;
  logic [1:0]  mac_config_aw;
  logic [6:0]  mac_config_sc;
  logic [31:0] mac_z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_z;
  logic [1:0]  res_mode;

  typedef struct packed {
    logic [31:0] z;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  mac_multiplex_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a),
    .mac_w(mac_w), .mac_a(mac_a), .mac_accu_rst(mac_accu_rst),
    .mac_config_aw(mac_config_aw), .mac_config_sc(mac_config_sc), .mac_z(mac_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_mode(res_mode)
  );

  mac_multiplex u_mac (
    .clk(clk), .rst(rst), .w(mac_w), .a(mac_a), .accu_rst(mac_accu_rst),
    .config_aw(mac_config_aw), .config_sc(mac_config_sc), .z(mac_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Independent reference: per-lane signed x unsigned product times beats,
  // wrapped to the lane width of the packed result word.
  function automatic logic [31:0] model_z(input logic [1:0] mode, input logic [7:0] w,
                                          input logic [7:0] a, input int beats);
    int lanes, lw, zl, wv, av;
    longint s;
    logic [63:0] lane_mask;
    logic [31:0] r;
    lanes = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    lw = 8 / lanes;
    zl = 32 / lanes;
    lane_mask = (64'd1 << zl) - 64'd1;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      wv = (int'(w) >> (i * lw)) & ((1 << lw) - 1);
      if (wv >= (1 << (lw - 1))) wv = wv - (1 << lw);
      av = (int'(a) >> (i * lw)) & ((1 << lw) - 1);
      s = longint'(wv) * longint'(av) * longint'(beats);
      r = r | 32'((64'(s) & lane_mask) << (i * zl));
    end
    return r;
  endfunction

  // Launch a job and feed identical beats; reports start/last-beat edges,
  // operand-path errors and the config seen in the CLEAR cycle.
  task automatic drive_job(input logic [1:0] mode, input logic [15:0] len,
                           input logic [7:0] w, input logic [7:0] a,
                           input bit bubbles, input bit noisy_start,
                           output int start_edge, output int last_edge, output int op_errs,
                           output logic clr_obs, output logic [1:0] aw_obs,
                           output logic [6:0] sc_obs);
    int beats, guard;
    logic v, rdy;
    bit first_ready;
    start = 1'b1; cfg_mode = mode; cfg_len = len; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = cyc; last_edge = cyc; op_errs = 0;
    clr_obs = mac_accu_rst; aw_obs = mac_config_aw; sc_obs = mac_config_sc;
    beats = 0; guard = 0; first_ready = 1'b1;
    while (beats < int'(len) && guard < 400) begin
      rdy = in_ready;
      v = bubbles ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (bubbles && rdy && first_ready) v = 1'b0;
      if (rdy) first_ready = 1'b0;
      in_valid = v; in_w = w; in_a = a;
      if (noisy_start) begin
        start = rdy; cfg_mode = 2'd1; cfg_len = 16'd1;
      end
      #1;
      if (mac_w !== ((v && rdy) ? w : 8'h00) || mac_a !== ((v && rdy) ? a : 8'h00))
        op_errs++;
      if (v && rdy) begin
        beats++;
        last_edge = cyc + 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (beats < int'(len)) op_errs++;
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output bit got, output logic [31:0] z,
                             output logic [1:0] m, output int at);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    got = res_valid; z = res_z; m = res_mode; at = cyc;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cfg_mode = 2'd2; cfg_len = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid got=%0b want=0", res_valid); end
    total++; if (res_z !== 32'h0) begin bad++; $display("[TB] FAIL reset_res_z got=%h want=0", res_z); end
    total++; if (res_mode !== 2'd0) begin bad++; $display("[TB] FAIL reset_res_mode got=%0d want=0", res_mode); end
    total++; if (mac_accu_rst !== 1'b0) begin bad++; $display("[TB] FAIL reset_accu_rst got=%0b want=0", mac_accu_rst); end
    total++; if (mac_w !== 8'h0 || mac_a !== 8'h0) begin bad++; $display("[TB] FAIL reset_operands got=%h/%h want=00/00", mac_w, mac_a); end
    total++; if (mac_config_aw !== 2'b00) begin bad++; $display("[TB] FAIL reset_aw got=%b want=00", mac_config_aw); end
    total++; if (mac_config_sc !== 7'b0101000) begin bad++; $display("[TB] FAIL reset_sc got=%b want=0101000", mac_config_sc); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    int se, le, oe, at; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{32'hFFFFFFD3, 2'd0});
    drive_job(2'd0, 16'd3, 8'hFD, 8'd5, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
    in_valid = 1'b1; in_w = 8'hFF; in_a = 8'hFF; #1;
    total++; if (mac_w !== 8'h0 || mac_a !== 8'h0) begin bad++; $display("[TB] FAIL full_drain_operands got=%h/%h want=00/00", mac_w, mac_a); end
    in_valid = 1'b0;
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL full_timeout got=no_result want=res_valid"); end
    total++; if (z !== e.z) begin bad++; $display("[TB] FAIL full_z got=%h want=%h", z, e.z); end
    total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL full_mode got=%0d want=%0d", m, e.mode); end
    total++; if (at !== le + 2) begin bad++; $display("[TB] FAIL full_latency got=%0d want=%0d", at, le + 2); end
    total++; if (clr !== 1'b1) begin bad++; $display("[TB] FAIL full_clear_pulse got=%0b want=1", clr); end
    total++; if (aw !== 2'b00 || sc !== 7'b0101000) begin bad++; $display("[TB] FAIL full_config got=%b/%b want=00/0101000", aw, sc); end
    total++; if (oe !== 0) begin bad++; $display("[TB] FAIL full_operand_path got=%0d want=0", oe); end
    ack();
  endtask

  task automatic test_half();
    int se, le, oe, at; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{32'hFFFD000E, 2'd1});
    drive_job(2'd1, 16'd1, 8'hF2, 8'h37, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL half_z got=%h want=%h", z, e.z); end
    total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL half_mode got=%0d want=%0d", m, e.mode); end
    total++; if (aw !== 2'b01 || sc !== 7'b0100110) begin bad++; $display("[TB] FAIL half_config got=%b/%b want=01/0100110", aw, sc); end
    total++; if (at !== le + 2) begin bad++; $display("[TB] FAIL half_latency got=%0d want=%0d", at, le + 2); end
    ack();
  endtask

  task automatic test_quarter_bubbles();
    int se, le, oe, at; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{32'hFA04FC06, 2'd2});
    drive_job(2'd2, 16'd2, 8'b11011001, 8'b11100111, 1'b1, 1'b0, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL quarter_z got=%h want=%h", z, e.z); end
    total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL quarter_mode got=%0d want=%0d", m, e.mode); end
    total++; if (aw !== 2'b11 || sc !== 7'b0000101) begin bad++; $display("[TB] FAIL quarter_config got=%b/%b want=11/0000101", aw, sc); end
    total++; if (oe !== 0) begin bad++; $display("[TB] FAIL quarter_bubble_operands got=%0d want=0", oe); end
    total++; if (at !== le + 2) begin bad++; $display("[TB] FAIL quarter_latency got=%0d want=%0d", at, le + 2); end
    ack();
  endtask

  task automatic test_back_to_back();
    int se, le, oe, at; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{model_z(2'd2, 8'h6B, 8'hC4, 3), 2'd2});
    drive_job(2'd2, 16'd3, 8'h6B, 8'hC4, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL b2b_first_z got=%h want=%h", z, e.z); end
    ack();
    sb.push_back(exp_t'{32'h00000001, 2'd0});
    drive_job(2'd0, 16'd1, 8'd1, 8'd1, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL b2b_second_z got=%h want=%h", z, e.z); end
    total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL b2b_second_mode got=%0d want=%0d", m, e.mode); end
    total++; if (at !== le + 2) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=%0d", at, le + 2); end
    ack();
  endtask

  task automatic test_len_zero();
    int se, le, oe, at; logic clr; logic [1:0] aw, m, md, want_mode; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    for (int k = 0; k < 2; k++) begin
      md = (k == 0) ? 2'd3 : 2'd1;
      want_mode = (k == 0) ? 2'd0 : 2'd1;
      sb.push_back(exp_t'{32'h0, want_mode});
      drive_job(md, 16'd0, 8'h77, 8'h33, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
      wait_result(40, got, z, m, at);
      e = sb.pop_front();
      total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL len0_z mode=%0d got=%h want=%h", md, z, e.z); end
      total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL len0_mode got=%0d want=%0d", m, e.mode); end
      total++; if (at !== se + 3) begin bad++; $display("[TB] FAIL len0_latency got=%0d want=%0d", at, se + 3); end
      total++; if (aw !== ((k == 0) ? 2'b00 : 2'b01)) begin bad++; $display("[TB] FAIL len0_aw got=%b want=%b", aw, (k == 0) ? 2'b00 : 2'b01); end
      ack();
    end
  endtask

  task automatic test_start_ignored();
    int se, le, oe, at; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{32'd24, 2'd0});
    drive_job(2'd0, 16'd4, 8'd2, 8'd3, 1'b0, 1'b1, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL run_start_z got=%h want=%h", z, e.z); end
    total++; if (m !== e.mode) begin bad++; $display("[TB] FAIL run_start_mode got=%0d want=%0d", m, e.mode); end
    total++; if (mac_config_aw !== 2'b00) begin bad++; $display("[TB] FAIL run_start_aw got=%b want=00", mac_config_aw); end
    start = 1'b1; cfg_mode = 2'd2; cfg_len = 16'd5; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL done_start_busy got=%0b want=0", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL done_start_idle got=%0b want=0", busy); end
  endtask

  task automatic test_rst_mid_run();
    logic [1:0] md;
    for (int k = 0; k < 2; k++) begin
      md = (k == 0) ? 2'd0 : 2'd1;
      start = 1'b1; cfg_mode = md; cfg_len = 16'd6;
      in_valid = 1'b1; in_w = 8'h05; in_a = 8'h05;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy mode=%0d got=%0b want=0", md, busy); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready got=%0b want=0", in_ready); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_res_valid got=%0b want=0", res_valid); end
      total++; if (mac_config_aw !== 2'b00 || mac_config_sc !== 7'b0101000) begin bad++; $display("[TB] FAIL rst_config got=%b/%b want=00/0101000", mac_config_aw, mac_config_sc); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_stays_idle got=%0b/%0b want=0/0", busy, res_valid); end
    end
  endtask

  task automatic test_hold();
    int se, le, oe, at, hold_err; logic clr; logic [1:0] aw, m; logic [6:0] sc;
    bit got; logic [31:0] z; exp_t e;
    sb.push_back(exp_t'{model_z(2'd0, 8'd7, 8'd9, 2), 2'd0});
    drive_job(2'd0, 16'd2, 8'd7, 8'd9, 1'b0, 1'b0, se, le, oe, clr, aw, sc);
    wait_result(40, got, z, m, at);
    e = sb.pop_front();
    hold_err = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_z !== z || res_valid !== 1'b1 || res_mode !== m) hold_err++;
    end
    total++; if (z !== e.z || !got) begin bad++; $display("[TB] FAIL after_rst_z got=%h want=%h", z, e.z); end
    total++; if (hold_err !== 0) begin bad++; $display("[TB] FAIL hold_stable got=%0d want=0", hold_err); end
    ack();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_release got=%0b/%0b want=0/0", busy, res_valid); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = 2'd0; cfg_len = 16'd0;
    in_valid = 1'b0; in_w = 8'h0; in_a = 8'h0; res_ready = 1'b0;
    test_reset();
    test_full();
    test_half();
    test_quarter_bubbles();
    test_back_to_back();
    test_len_zero();
    test_start_ignored();
    test_rst_mid_run();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
